// File: rtl/rram_addr_sequencer.sv
// RRAM word-address sequencer: walks start..stop by step (or one address)
// and hands addresses to the programming/read FSM via a next handshake.
module rram_addr_sequencer #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic              go,
    input  logic              abort,
    input  logic              use_multi_addrs,
    input  logic [ADDR_W-1:0] address_start,
    input  logic [ADDR_W-1:0] address_stop,
    input  logic [ADDR_W-1:0] address_step,
    input  logic              next,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    output logic              addr_last,
    output logic              done,
    output logic              range_err,
    output logic [CNT_W-1:0]  addr_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << ADDR_W;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W-1:0] stop_q, stop_d;
    logic [ADDR_W-1:0] step_q, step_d;
    logic              multi_q, multi_d;
    logic              range_err_q, range_err_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W:0]   sum;
    logic              last;

    // One extra bit so a step that wraps past the top is seen as the end.
    assign sum = {1'b0, addr_q} + {1'b0, step_q};

    assign last = !multi_q
               || (step_q == '0)
               || (addr_q == stop_q)
               || sum[ADDR_W]
               || (sum[ADDR_W-1:0] > stop_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        multi_d     = multi_q;
        range_err_d = range_err_q;
        count_d     = count_q;

        case (state_q)
            S_IDLE: begin
                if (go && abort) begin
                    state_d = S_FIN;
                end else if (go) begin
                    start_d     = address_start;
                    stop_d      = address_stop;
                    step_d      = address_step;
                    multi_d     = use_multi_addrs;
                    addr_d      = address_start;
                    count_d     = '0;
                    range_err_d = use_multi_addrs
                               && (address_start > address_stop);
                    state_d     = range_err_d ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                // abort beats next: the current address is not retired
                if (abort) begin
                    state_d = S_FIN;
                end else if (next) begin
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (last) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d = sum[ADDR_W-1:0];
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            multi_q     <= 1'b0;
            range_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            multi_q     <= multi_d;
            range_err_q <= range_err_d;
            count_q     <= count_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = (state_q == S_RUN);
    assign addr_last  = addr_valid && last;
    assign done       = (state_q == S_FIN);
    assign range_err  = range_err_q;
    assign addr_count = count_q;

endmodule

// File: tb/tb_rram_addr_sequencer.sv
// Bench for rram_addr_sequencer: table of sweeps checked through an
// address scoreboard, plus hand sequences for abort, reset and idle cases.
module tb_rram_addr_sequencer;

    logic        mclk;
    logic        rst;
    logic        go;
    logic        abort;
    logic        multi_i;
    logic [15:0] start_i;
    logic [15:0] stop_i;
    logic [15:0] step_i;
    logic        next;
    logic [15:0] addr;
    logic        addr_valid;
    logic        addr_last;
    logic        done;
    logic        range_err;
    logic [16:0] addr_count;

    rram_addr_sequencer dut (
        .mclk            (mclk),
        .rst             (rst),
        .go              (go),
        .abort           (abort),
        .use_multi_addrs (multi_i),
        .address_start   (start_i),
        .address_stop    (stop_i),
        .address_step    (step_i),
        .next            (next),
        .addr            (addr),
        .addr_valid      (addr_valid),
        .addr_last       (addr_last),
        .done            (done),
        .range_err       (range_err),
        .addr_count      (addr_count)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    typedef struct {
        logic        multi;
        logic [15:0] start;
        logic [15:0] stop;
        logic [15:0] step;
        int          exp_n;
        logic        exp_rerr;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic        last;
    } exp_t;

    localparam int NV = 9;
    vec_t tbl [NV];
    exp_t sb [$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int k);
        vec_t v;
        exp_t e;
        int   cyc;
        v = tbl[k];
        @(negedge mclk);
        multi_i = v.multi;
        start_i = v.start;
        stop_i  = v.stop;
        step_i  = v.step;
        go      = 1'b1;
        for (int i = 0; i < v.exp_n; i++) begin
            e.addr = v.start + 16'(i) * v.step;
            e.last = (i == v.exp_n - 1);
            sb.push_back(e);
        end
        @(negedge mclk);
        go      = 1'b0;
        start_i = 16'($urandom);
        stop_i  = 16'($urandom);
        step_i  = 16'($urandom);
        multi_i = 1'($urandom);
        chk($sformatf("v%0d first_valid", k), addr_valid, !v.exp_rerr);
        chk($sformatf("v%0d range_err", k), range_err, v.exp_rerr);
        cyc = 0;
        while (!done && cyc < 100) begin
            if (addr_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL v%0d extra_addr: got %h expected none",
                             k, addr);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d addr", k), addr, e.addr);
                    chk($sformatf("v%0d last", k), addr_last, e.last);
                end
                next = 1'b1;
            end else begin
                next = 1'b0;
            end
            @(negedge mclk);
            cyc++;
        end
        next = 1'b0;
        chk($sformatf("v%0d done_seen", k), done, 1'b1);
        chk($sformatf("v%0d leftover", k), sb.size(), 0);
        sb.delete();
        chk($sformatf("v%0d count", k), addr_count, v.exp_n);
        chk($sformatf("v%0d rerr_end", k), range_err, v.exp_rerr);
        chk($sformatf("v%0d fin_valid", k), addr_valid, 1'b0);
        @(negedge mclk);
        chk($sformatf("v%0d done_pulse", k), done, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b0, 16'h0123, 16'h0000, 16'h0005, 1, 1'b0};
        tbl[1] = '{1'b1, 16'h0010, 16'h0020, 16'h0004, 5, 1'b0};
        tbl[2] = '{1'b1, 16'hFFF0, 16'hFFFF, 16'h0020, 1, 1'b0};
        tbl[3] = '{1'b1, 16'h0040, 16'h0010, 16'h0001, 0, 1'b1};
        tbl[4] = '{1'b1, 16'h0100, 16'h0100, 16'h0003, 1, 1'b0};
        tbl[5] = '{1'b1, 16'h0000, 16'h0007, 16'h0000, 1, 1'b0};
        tbl[6] = '{1'b1, 16'h0005, 16'h001A, 16'h0007, 4, 1'b0};
        tbl[7] = '{1'b1, 16'hFFFC, 16'hFFFF, 16'h0001, 4, 1'b0};
        tbl[8] = '{1'b1, 16'h0001, 16'h0012, 16'h0005, 4, 1'b0};

        rst     = 1'b1;
        go      = 1'b0;
        abort   = 1'b0;
        next    = 1'b0;
        multi_i = 1'b0;
        start_i = 16'h0;
        stop_i  = 16'h0;
        step_i  = 16'h0;
        repeat (3) @(negedge mclk);
        chk("rst addr", addr, 16'h0);
        chk("rst valid", addr_valid, 1'b0);
        chk("rst last", addr_last, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst rerr", range_err, 1'b0);
        chk("rst count", addr_count, 17'h0);
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            run_vec(k);
        end

        // abort together with next on the third address; go in RUN ignored
        @(negedge mclk);
        multi_i = 1'b1;
        start_i = 16'h0000;
        stop_i  = 16'h000F;
        step_i  = 16'h0001;
        go      = 1'b1;
        @(negedge mclk);
        go = 1'b0;
        chk("ab addr0", addr, 16'h0000);
        chk("ab valid0", addr_valid, 1'b1);
        next = 1'b1;
        @(negedge mclk);
        chk("ab addr1", addr, 16'h0001);
        go = 1'b1;
        @(negedge mclk);
        go = 1'b0;
        chk("ab addr2", addr, 16'h0002);
        chk("ab count2", addr_count, 17'd2);
        chk("ab valid2", addr_valid, 1'b1);
        abort = 1'b1;
        @(negedge mclk);
        next  = 1'b0;
        abort = 1'b0;
        chk("ab done", done, 1'b1);
        chk("ab valid", addr_valid, 1'b0);
        chk("ab count", addr_count, 17'd2);
        chk("ab addr_hold", addr, 16'h0002);
        @(negedge mclk);
        chk("ab done_pulse", done, 1'b0);
        chk("ab no_restart", addr_valid, 1'b0);

        // next in IDLE is ignored; abort alone in IDLE has no effect
        next = 1'b1;
        @(negedge mclk);
        next = 1'b0;
        chk("idle next count", addr_count, 17'd2);
        chk("idle next valid", addr_valid, 1'b0);
        abort = 1'b1;
        @(negedge mclk);
        chk("idle abort done", done, 1'b0);
        go = 1'b1;
        @(negedge mclk);
        go    = 1'b0;
        abort = 1'b0;
        chk("goabort done", done, 1'b1);
        chk("goabort valid", addr_valid, 1'b0);
        @(negedge mclk);
        chk("goabort pulse", done, 1'b0);
        chk("goabort idle", addr_valid, 1'b0);

        // reset in the middle of a sweep
        start_i = 16'h0030;
        stop_i  = 16'h00F0;
        step_i  = 16'h0010;
        multi_i = 1'b1;
        go      = 1'b1;
        @(negedge mclk);
        go   = 1'b0;
        next = 1'b1;
        @(negedge mclk);
        next = 1'b0;
        chk("mid addr", addr, 16'h0040);
        chk("mid count", addr_count, 17'd1);
        rst = 1'b1;
        @(negedge mclk);
        chk("mrst addr", addr, 16'h0);
        chk("mrst valid", addr_valid, 1'b0);
        chk("mrst last", addr_last, 1'b0);
        chk("mrst done", done, 1'b0);
        chk("mrst rerr", range_err, 1'b0);
        chk("mrst count", addr_count, 17'h0);
        rst = 1'b0;
        @(negedge mclk);
        chk("mrst no_done", done, 1'b0);
        chk("mrst idle", addr_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
